// File: rtl/mem_fill_arbiter_if.sv
// rtl/mem_fill_arbiter_if.sv - cache-miss / store / memory signal bundle for the fill arbiter
// master is the arbiter side, slave is the caches plus memory model.
interface mem_fill_arbiter_if #(
   parameter int ADDR_W    = 16,
   parameter int BLK_WORDS = 8
);
   logic                         i_miss;
   logic [ADDR_W-1:0]            i_miss_addr;
   logic                         d_miss;
   logic [ADDR_W-1:0]            d_miss_addr;
   logic                         d_wr;
   logic [ADDR_W-1:0]            d_wr_addr;
   logic [ADDR_W-1:0]            d_wr_data;
   logic [ADDR_W-1:0]            mem_data_in;
   logic                         mem_data_valid;
   logic [ADDR_W-1:0]            mem_addr;
   logic [ADDR_W-1:0]            mem_data_out;
   logic                         mem_enable;
   logic                         mem_wr;
   logic [ADDR_W-1:0]            fill_data;
   logic [$clog2(BLK_WORDS)-1:0] fill_word;
   logic                         i_fill_we;
   logic                         d_fill_we;
   logic                         i_fill_done;
   logic                         d_fill_done;
   logic                         d_wr_ack;
   logic                         busy;

   modport master (
      input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
             mem_data_in, mem_data_valid,
      output mem_addr, mem_data_out, mem_enable, mem_wr, fill_data, fill_word,
             i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy
   );

   modport slave (
      output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
             mem_data_in, mem_data_valid,
      input  mem_addr, mem_data_out, mem_enable, mem_wr, fill_data, fill_word,
             i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy
   );
endinterface

// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - shares main memory between I/D block fills and D-side write-through stores
// Outputs are decoded combinationally from the registered state, so reset clears them immediately.
module mem_fill_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int BLK_WORDS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_fill_arbiter_if.master  bus
);
   localparam int WORD_W = $clog2(BLK_WORDS);
   localparam int CNT_W  = WORD_W + 1;
   localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLK_WORDS * 2 - 1);

   typedef enum logic [1:0] {IDLE, D_WRITE, I_FILL, D_FILL} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_base;
   logic [CNT_W-1:0]   r_issue_cnt;
   logic [CNT_W-1:0]   r_ret_cnt;
   logic               r_issue_done;
   logic               w_filling;
   logic               w_blk_full;
   logic               w_ret;

   assign w_filling  = (r_state == I_FILL) || (r_state == D_FILL);
   assign w_blk_full = (r_ret_cnt == CNT_W'(BLK_WORDS));
   // Returns outside a fill, or beyond the last word, are dropped.
   assign w_ret      = w_filling && bus.mem_data_valid && !w_blk_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.d_wr)        w_next = D_WRITE;
            else if (bus.d_miss) w_next = D_FILL;
            else if (bus.i_miss) w_next = I_FILL;
         end
         D_WRITE:        w_next = IDLE;
         I_FILL, D_FILL: if (w_blk_full) w_next = IDLE;
         default:        w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base       <= '0;
         r_issue_cnt  <= '0;
         r_ret_cnt    <= '0;
         r_issue_done <= 1'b0;
      end else if (r_state == IDLE) begin
         r_issue_cnt  <= '0;
         r_ret_cnt    <= '0;
         r_issue_done <= 1'b0;
         if (w_next == D_FILL)      r_base <= bus.d_miss_addr & ~BLK_MASK;
         else if (w_next == I_FILL) r_base <= bus.i_miss_addr & ~BLK_MASK;
      end else if (w_filling) begin
         // A separate done flag keeps issue stopped even though the counter can reach BLK_WORDS.
         if (!r_issue_done) begin
            r_issue_cnt  <= r_issue_cnt + 1'b1;
            r_issue_done <= (r_issue_cnt == CNT_W'(BLK_WORDS - 1));
         end
         if (w_ret) r_ret_cnt <= r_ret_cnt + 1'b1;
      end
   end

   always_comb begin
      bus.mem_addr     = '0;
      bus.mem_data_out = '0;
      bus.mem_enable   = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.fill_data    = '0;
      bus.fill_word    = '0;
      bus.i_fill_we    = 1'b0;
      bus.d_fill_we    = 1'b0;
      bus.i_fill_done  = 1'b0;
      bus.d_fill_done  = 1'b0;
      bus.d_wr_ack     = 1'b0;
      bus.busy         = (r_state != IDLE);
      case (r_state)
         D_WRITE: begin
            bus.mem_enable   = 1'b1;
            bus.mem_wr       = 1'b1;
            bus.mem_addr     = bus.d_wr_addr;
            bus.mem_data_out = bus.d_wr_data;
            bus.d_wr_ack     = 1'b1;
         end
         I_FILL, D_FILL: begin
            if (!r_issue_done) begin
               bus.mem_enable = 1'b1;
               bus.mem_addr   = r_base + (ADDR_W'(r_issue_cnt) << 1);
            end
            if (w_ret) begin
               bus.fill_data = bus.mem_data_in;
               bus.fill_word = r_ret_cnt[WORD_W-1:0];
               bus.i_fill_we = (r_state == I_FILL);
               bus.d_fill_we = (r_state == D_FILL);
            end
            if (w_blk_full) begin
               bus.i_fill_done = (r_state == I_FILL);
               bus.d_fill_done = (r_state == D_FILL);
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - directed bench for mem_fill_arbiter with a fixed-latency memory model
module tb_mem_fill_arbiter;
   localparam int MEM_LAT = 4;

   logic clk;
   logic rst_n;
   logic stray_v;
   logic [15:0] stray_d;
   int compared;
   int failed;

   mem_fill_arbiter_if #(.ADDR_W(16), .BLK_WORDS(8)) bus();

   mem_fill_arbiter #(.ADDR_W(16), .BLK_WORDS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: a read issued in cycle c returns addr^0xA5A5 in cycle c+MEM_LAT.
   logic [MEM_LAT-1:0] r_pv;
   logic [15:0]        r_pa [MEM_LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pv <= '0;
         for (int i = 0; i < MEM_LAT; i++) r_pa[i] <= '0;
      end else begin
         r_pv    <= {r_pv[MEM_LAT-2:0], bus.mem_enable & ~bus.mem_wr};
         r_pa[0] <= bus.mem_addr;
         for (int i = 1; i < MEM_LAT; i++) r_pa[i] <= r_pa[i-1];
      end
   end
   assign bus.mem_data_valid = r_pv[MEM_LAT-1] | stray_v;
   assign bus.mem_data_in    = stray_v ? stray_d : (r_pa[MEM_LAT-1] ^ 16'hA5A5);

   function automatic logic [58:0] pk(input logic en, input logic wr, input logic [15:0] a,
                                      input logic [15:0] dout, input logic iwe, input logic dwe,
                                      input logic [2:0] w, input logic [15:0] fd, input logic idn,
                                      input logic ddn, input logic ack, input logic bsy);
      return {en, wr, a, dout, iwe, dwe, w, fd, idn, ddn, ack, bsy};
   endfunction

   function automatic logic [58:0] obs();
      return pk(bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_out, bus.i_fill_we,
                bus.d_fill_we, bus.fill_word, bus.fill_data, bus.i_fill_done, bus.d_fill_done,
                bus.d_wr_ack, bus.busy);
   endfunction

   // Expected outputs k cycles after the grant edge of a fill (k = 1..13).
   function automatic logic [58:0] exp_fill(input int k, input logic [15:0] base, input logic is_d);
      logic en, we, dn;
      logic [15:0] a, ra;
      en = (k >= 1 && k <= 8);
      we = (k >= 5 && k <= 12);
      dn = (k == 13);
      a  = en ? base + 16'(2 * (k - 1)) : 16'h0;
      ra = base + 16'(2 * (k - 5));
      return pk(en, 1'b0, a, 16'h0, we && !is_d, we && is_d, we ? 3'(k - 5) : 3'd0,
                we ? (ra ^ 16'hA5A5) : 16'h0, dn && !is_d, dn && is_d, 1'b0, 1'b1);
   endfunction

   task automatic test_reset();
      logic [58:0] o;
      repeat (2) @(negedge clk);
      #1 o = obs();
      compared++;
      if (o !== 59'h0) begin failed++; $display("FAIL reset_idle got %h exp 0", o); end
      rst_n = 1'b1;
      @(negedge clk);
      bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0126;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1 o = obs();
      compared++;
      if (o !== 59'h0) begin failed++; $display("FAIL reset_midfill got %h exp 0", o); end
      @(negedge clk);
      bus.i_miss = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_i_fill();
      logic [58:0] o, e;
      @(negedge clk);
      bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0126;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk); #1;
         o = obs();
         e = (k <= 13) ? exp_fill(k, 16'h0120, 1'b0) : 59'h0;
         compared++;
         if (o !== e) begin failed++; $display("FAIL i_fill k=%0d got %h exp %h", k, o, e); end
         if (k == 13) bus.i_miss = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [58:0] o, e;
      @(negedge clk);
      bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1238;
      bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2345;
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk); #1;
         o = obs();
         if (k <= 13)      e = exp_fill(k, 16'h2340, 1'b1);
         else if (k == 14) e = 59'h0;
         else if (k <= 27) e = exp_fill(k - 14, 16'h1230, 1'b0);
         else              e = 59'h0;
         compared++;
         if (o !== e) begin failed++; $display("FAIL back_to_back k=%0d got %h exp %h", k, o, e); end
         if (k == 13) bus.d_miss = 1'b0;
         if (k == 27) bus.i_miss = 1'b0;
      end
   endtask

   task automatic test_store_waits();
      logic [58:0] o, e;
      @(negedge clk);
      bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0126;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); #1;
         o = obs();
         if (k <= 13)      e = exp_fill(k, 16'h0120, 1'b0);
         else if (k == 15) e = pk(1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 3'd0, 16'h0,
                                  1'b0, 1'b0, 1'b1, 1'b1);
         else              e = 59'h0;
         compared++;
         if (o !== e) begin failed++; $display("FAIL store_waits k=%0d got %h exp %h", k, o, e); end
         if (k == 8) begin bus.d_wr = 1'b1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF; end
         if (k == 13) bus.i_miss = 1'b0;
         if (k == 15) bus.d_wr = 1'b0;
      end
   endtask

   task automatic test_reset_restart();
      logic [58:0] o, e;
      @(negedge clk);
      bus.d_miss = 1'b1; bus.d_miss_addr = 16'h3456;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk); #1;
         o = obs();
         e = exp_fill(k, 16'h3450, 1'b1);
         compared++;
         if (o !== e) begin failed++; $display("FAIL partial k=%0d got %h exp %h", k, o, e); end
      end
      rst_n = 1'b0;
      #1 o = obs();
      compared++;
      if (o !== 59'h0) begin failed++; $display("FAIL reset_partial got %h exp 0", o); end
      @(negedge clk);
      bus.d_miss_addr = 16'h5678;
      rst_n = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk); #1;
         o = obs();
         e = (k <= 13) ? exp_fill(k, 16'h5670, 1'b1) : 59'h0;
         compared++;
         if (o !== e) begin failed++; $display("FAIL restart k=%0d got %h exp %h", k, o, e); end
         if (k == 13) bus.d_miss = 1'b0;
      end
   endtask

   task automatic test_top_of_map();
      logic [58:0] o, e;
      @(negedge clk);
      bus.d_miss = 1'b1; bus.d_miss_addr = 16'hFFFB;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 13) begin stray_v = 1'b1; stray_d = 16'h1234; end
         #1;
         o = obs();
         e = (k <= 13) ? exp_fill(k, 16'hFFF0, 1'b1) : 59'h0;
         compared++;
         if (o !== e) begin failed++; $display("FAIL top_of_map k=%0d got %h exp %h", k, o, e); end
         if (k == 13) bus.d_miss = 1'b0;
      end
      stray_v = 1'b0;
   endtask

   initial begin
      compared = 0;
      failed   = 0;
      rst_n    = 1'b0;
      stray_v  = 1'b0;
      stray_d  = 16'h0;
      bus.i_miss = 1'b0; bus.i_miss_addr = 16'h0;
      bus.d_miss = 1'b0; bus.d_miss_addr = 16'h0;
      bus.d_wr   = 1'b0; bus.d_wr_addr   = 16'h0; bus.d_wr_data = 16'h0;
      test_reset();
      test_i_fill();
      test_back_to_back();
      test_store_waits();
      test_reset_restart();
      test_top_of_map();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
